// File: rtl/quokka_panel_pkg.sv
// Shared types and default widths for front-panel sequencers.
// Exports state_t (IDLE/REQ/ACC/DONE), op_t (OP_RD/OP_WR).
package quokka_panel_pkg;

  localparam int PANEL_ADDR_W = 16;
  localparam int PANEL_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACC,
    DONE
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

endpackage

// File: rtl/panel_timeout.sv
// Loadable down-counter with clear and enable; expired when count is 0.
// Ports: clk, rst_n, clr, load, load_val[W], en -> expired.
module panel_timeout
  import quokka_panel_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/panel_bus_sequencer.sv
// Front-panel memory sequencer: load/inc/dec/exam/dep over shared bus.
// Ports: cmd pulses, disp_val in; bus_req/mem_* bus side; addr/data/err UI.
// Optional macro PANEL_AUTO_INC_EN: successful deposit advances addr.
module panel_bus_sequencer
  import quokka_panel_pkg::*;
#(
  parameter int ADDR_W  = PANEL_ADDR_W,
  parameter int DATA_W  = PANEL_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stopped,
  input  logic              cmd_load,
  input  logic              cmd_inc,
  input  logic              cmd_dec,
  input  logic              cmd_exam,
  input  logic              cmd_dep,
  input  logic [23:0]       disp_val,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              busy,
  output logic              err,
  output logic              clear_disp
);

  localparam int TW = $clog2(TIMEOUT + 1);
  // Loaded with TIMEOUT-1 so bus_req stays up exactly TIMEOUT cycles.
  localparam logic [TW-1:0] TMO_LD = TW'(TIMEOUT - 1);

  state_t state, state_n;
  op_t    op;
  logic   any_cmd;
  logic   accept;
  logic   tmo_exp;
  logic   tmo_fire;
  logic   unused_disp;

  assign any_cmd = cmd_load | cmd_inc | cmd_dec | cmd_exam | cmd_dep;
  assign accept  = (state == IDLE) & stopped & any_cmd;
  assign unused_disp = ^disp_val;

  panel_timeout #(
    .W(TW)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     ((state == IDLE) & ~accept),
    .load    (accept),
    .load_val(TMO_LD),
    .en      (bus_req),
    .expired (tmo_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    tmo_fire   = 1'b0;
    bus_req    = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    clear_disp = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_n = REQ;
      end
      REQ: begin
        bus_req = 1'b1;
        if (!stopped) begin
          state_n = IDLE;
        end else if (bus_gnt) begin
          state_n = ACC;
        end else if (tmo_exp) begin
          state_n  = IDLE;
          tmo_fire = 1'b1;
        end
      end
      ACC: begin
        bus_req = 1'b1;
        mem_re  = (op == OP_RD);
        mem_we  = (op == OP_WR);
        if (mem_ack) begin
          state_n = DONE;
        end else if (tmo_exp) begin
          state_n  = IDLE;
          tmo_fire = 1'b1;
        end
      end
      DONE: begin
        clear_disp = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign mem_addr = addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op         <= OP_RD;
      mem_wdata  <= '0;
      addr       <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (accept) begin
        err       <= 1'b0;
        mem_wdata <= disp_val[DATA_W-1:0];
        priority case (1'b1)
          cmd_load: begin
            addr       <= disp_val[ADDR_W-1:0];
            data_valid <= 1'b0;
            op         <= OP_RD;
          end
          cmd_dep: begin
            data_valid <= 1'b0;
            op         <= OP_WR;
          end
          cmd_exam: begin
            op <= OP_RD;
          end
          cmd_inc: begin
            addr       <= addr + 1'b1;
            data_valid <= 1'b0;
            op         <= OP_RD;
          end
          cmd_dec: begin
            addr       <= addr - 1'b1;
            data_valid <= 1'b0;
            op         <= OP_RD;
          end
          default: ;
        endcase
      end
      if (tmo_fire) err <= 1'b1;
      if (state == ACC && mem_ack) begin
        data       <= (op == OP_RD) ? mem_rdata : mem_wdata;
        data_valid <= 1'b1;
      end
`ifdef PANEL_AUTO_INC_EN
      if (state == DONE && op == OP_WR) begin
        addr       <= addr + 1'b1;
        data_valid <= 1'b0;
      end
`else
`endif
    end
  end

endmodule

// File: tb/tb_panel_bus_sequencer.sv
// Self-checking bench for panel_bus_sequencer.
// Directed scenarios plus random commands against a memory model.
module tb_panel_bus_sequencer;
  import quokka_panel_pkg::*;

  localparam int TMO = 255;
  localparam int K_LOAD = 0;
  localparam int K_DEP  = 1;
  localparam int K_EXAM = 2;
  localparam int K_INC  = 3;
  localparam int K_DEC  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stopped = 1'b0;
  logic        cmd_load = 1'b0;
  logic        cmd_inc = 1'b0;
  logic        cmd_dec = 1'b0;
  logic        cmd_exam = 1'b0;
  logic        cmd_dep = 1'b0;
  logic [23:0] disp_val = '0;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        data_valid;
  logic        busy;
  logic        err;
  logic        clear_disp;

  always #5 clk = ~clk;

  panel_bus_sequencer #(
    .ADDR_W (16),
    .DATA_W (8),
    .TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stopped   (stopped),
    .cmd_load  (cmd_load),
    .cmd_inc   (cmd_inc),
    .cmd_dec   (cmd_dec),
    .cmd_exam  (cmd_exam),
    .cmd_dep   (cmd_dep),
    .disp_val  (disp_val),
    .bus_req   (bus_req),
    .bus_gnt   (bus_gnt),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .addr      (addr),
    .data      (data),
    .data_valid(data_valid),
    .busy      (busy),
    .err       (err),
    .clear_disp(clear_disp)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int n_clr   = 0;

  logic [7:0] phys [int];
  logic [7:0] refm [int];

  int         maddr  = 0;
  logic [7:0] mdata  = '0;
  logic       mvalid = 1'b0;
  logic       merr   = 1'b0;

  always @(posedge clk) begin
    if (mem_ack && (mem_re || mem_we)) n_acc <= n_acc + 1;
    if (clear_disp) n_clr <= n_clr + 1;
  end

  function automatic logic [7:0] seed_byte(int a);
    return 8'(a) ^ 8'(a >> 8) ^ 8'h5C;
  endfunction

  function automatic logic [7:0] phys_rd(int a);
    return phys.exists(a) ? phys[a] : seed_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(int a);
    return refm.exists(a) ? refm[a] : seed_byte(a);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(int mask, logic [23:0] dv);
    @(negedge clk);
    disp_val = dv;
    cmd_load = mask[K_LOAD];
    cmd_dep  = mask[K_DEP];
    cmd_exam = mask[K_EXAM];
    cmd_inc  = mask[K_INC];
    cmd_dec  = mask[K_DEC];
    @(negedge clk);
    cmd_load = 1'b0;
    cmd_dep  = 1'b0;
    cmd_exam = 1'b0;
    cmd_inc  = 1'b0;
    cmd_dec  = 1'b0;
  endtask

  task automatic run_op(int k, logic [23:0] dv, int gd, int ad,
                        int extra, bit poke);
    int         ea;
    bit         wr;
    int         na0;
    int         nc0;
    logic [7:0] ed;
    ea = maddr;
    case (k)
      K_LOAD:  ea = int'(dv[15:0]);
      K_INC:   ea = (maddr + 1) % 65536;
      K_DEC:   ea = (maddr + 65535) % 65536;
      default: ;
    endcase
    wr  = (k == K_DEP);
    na0 = n_acc;
    nc0 = n_clr;
    pulse((1 << k) | extra, dv);
    chk("req_state", {busy, bus_req, mem_re, mem_we}, 4'b1100);
    chk("accept_addr", addr, ea);
    chk("err_clear", err, 0);
    if (poke) pulse(1 << K_LOAD, ~dv);
    repeat (gd) @(negedge clk);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    chk("strobe", {bus_req, mem_re, mem_we}, wr ? 3'b101 : 3'b110);
    chk("mem_addr", mem_addr, ea);
    if (wr) chk("mem_wdata", mem_wdata, dv[7:0]);
    repeat (ad) @(negedge clk);
    chk("strobe_hold", {bus_req, mem_re | mem_we}, 2'b11);
    mem_rdata = phys_rd(int'(mem_addr));
    if (mem_we) phys[int'(mem_addr)] = mem_wdata;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    chk("done", {clear_disp, bus_req, busy}, 3'b101);
    @(negedge clk);
    if (wr) begin
      refm[ea] = dv[7:0];
      ed = dv[7:0];
    end else begin
      ed = ref_rd(ea);
    end
    maddr  = ea;
    mdata  = ed;
    mvalid = 1'b1;
    merr   = 1'b0;
`ifdef PANEL_AUTO_INC_EN
    if (wr) begin
      maddr  = (ea + 1) % 65536;
      mvalid = 1'b0;
    end
`endif
    chk("idle", {busy, clear_disp, err}, 0);
    chk("addr", addr, maddr);
    chk("data", data, mdata);
    chk("data_valid", data_valid, mvalid);
    chk("one_access", n_acc - na0, 1);
    chk("one_clear", n_clr - nc0, 1);
  endtask

  initial begin
    int na0;
    int nc0;
    int cnt;

    rst_n   = 1'b0;
    stopped = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outs", {bus_req, mem_re, mem_we, busy, err, clear_disp,
                       data_valid, addr, data, mem_addr, mem_wdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    phys[32'h1234] = 8'hA5;
    refm[32'h1234] = 8'hA5;
    run_op(K_LOAD, 24'h001234, 2, 1, 0, 1'b0);
    run_op(K_DEP, 24'h00005A, 0, 0, 0, 1'b0);

    run_op(K_LOAD, 24'h00FFFF, 0, 0, 0, 1'b0);
    run_op(K_INC, 24'h000000, 1, 0, 0, 1'b0);
    run_op(K_DEC, 24'h000000, 0, 2, 0, 1'b0);

    stopped = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pulse(1 << k, 24'h00ABCD);
      @(negedge clk);
      chk("gated_idle", {busy, bus_req}, 0);
      chk("gated_addr", addr, maddr);
    end
    stopped = 1'b1;

    run_op(K_LOAD, 24'h004321, 0, 0, 1 << K_DEC, 1'b0);
    run_op(K_EXAM, 24'h000777, 1, 0, 0, 1'b1);

    na0 = n_acc;
    nc0 = n_clr;
    pulse(1 << K_EXAM, 24'h0);
    cnt = 0;
    while (bus_req && cnt < 400) begin
      cnt++;
      @(negedge clk);
    end
    merr = 1'b1;
    chk("tmo_cycles", cnt, TMO);
    chk("tmo_err", err, merr);
    chk("tmo_idle", {busy, bus_req, mem_re, mem_we}, 0);
    chk("tmo_no_clear", n_clr - nc0, 0);
    chk("tmo_no_access", n_acc - na0, 0);
    chk("tmo_valid", data_valid, mvalid);
    run_op(K_EXAM, 24'h0, 0, 0, 0, 1'b0);

    na0 = n_acc;
    nc0 = n_clr;
    pulse(1 << K_EXAM, 24'h0);
    chk("abort_req", bus_req, 1);
    stopped = 1'b0;
    @(negedge clk);
    chk("abort_idle", {busy, bus_req, mem_re, mem_we}, 0);
    stopped = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_access", n_acc - na0, 0);
    chk("abort_no_clear", n_clr - nc0, 0);
    chk("abort_addr", addr, maddr);
    chk("abort_valid", data_valid, mvalid);

    for (int i = 0; i < 40; i++) begin
      run_op($urandom_range(0, 4), 24'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), 0, 1'b0);
    end

    pulse(1 << K_EXAM, 24'h0);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    chk("rst_acc", {bus_req, mem_re}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {bus_req, mem_re, mem_we, busy, err, clear_disp,
                      data_valid, addr, data, mem_addr, mem_wdata}, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    maddr  = 0;
    mdata  = '0;
    mvalid = 1'b0;
    merr   = 1'b0;
    run_op(K_INC, 24'h0, 0, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
